// File: rtl/hc595_hex_display_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the 74HC595 hex display driver:
//   - disp_state_t : frame sequencer states (IDLE, LOAD, SHIFT, LATCH)
//   - SEG_*        : bit positions inside a segment byte {dp,g,f,e,d,c,b,a}
//   - SEG_TABLE    : active-high a..g patterns for hex digits 0..F
// ----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } disp_state_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Indexed by nibble value; the first listed element is index 15 (F).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hc595_hex_display_if.sv
// ----------------------------------------------------------------------------
// hc595_hex_display_if
//   Word handshake between a producer and the hex display driver.
//   data_i  : 4*N_DIGITS hex nibbles, most significant nibble = leftmost digit
//   dp_i    : N_DIGITS decimal-point enables, MSB = leftmost digit
//   valid_i : producer offers a word
//   ready_o : driver is idle and takes the word on valid_i && ready_o
//   Modports: master (producer side), slave (driver side).
// ----------------------------------------------------------------------------
interface hc595_hex_display_if #(
  parameter int N_DIGITS = 8
);

  logic [4*N_DIGITS-1:0] data_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic                  valid_i;
  logic                  ready_o;

  modport master (
    output data_i,
    output dp_i,
    output valid_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  dp_i,
    input  valid_i,
    output ready_o
  );

endinterface

// File: rtl/hc595_hex_display_seg7_encoder.sv
// ----------------------------------------------------------------------------
// seg7_encoder
//   Combinational hex-nibble to segment-byte encoder.
//   nibble_i     : hex value 0..F
//   dp_i         : decimal point enable (kept even when blanked)
//   active_low_i : 1 inverts the byte so a 0 lights a segment
//   blank_i      : 1 suppresses a..g
//   seg_o        : {dp,g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module seg7_encoder
  import spi_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       active_low_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] seg_hi;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    seg_hi = 8'h00;
    if (!blank_i) begin
      seg_hi[SEG_G:SEG_A] = SEG_TABLE[nibble_i];
    end
    seg_hi[SEG_DP] = dp_i;
    seg_o = active_low_i ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/hc595_hex_display.sv
// ----------------------------------------------------------------------------
// hc595_hex_display
//   Drives a chain of N_DIGITS 74HC595 shift registers, one 7-segment digit
//   per stage. A captured word is encoded, shifted out leftmost digit first
//   and dp first within each byte, then latched with an RCLK pulse.
//
//   Parameters:
//     CLK_DIV        : clk_i cycles per sclk_o half-period (1..255)
//     N_DIGITS       : stages / digits in the chain
//     SEG_ACTIVE_LOW : 1 = a shifted 0 lights a segment
//   Ports:
//     clk_i  : clock, everything on the rising edge
//     rst_i  : synchronous active-high reset
//     bus    : hc595_hex_display_if.slave (data_i, dp_i, valid_i, ready_o)
//     sclk_o : SRCLK, idles low, ser_o changes on its falling side
//     ser_o  : SER
//     rclk_o : RCLK latch strobe, high for CLK_DIV cycles after the last bit
//
//   Build option: define HC595_BLANK_LEADING_ZEROS_EN to blank leading zero
//   digits (the rightmost digit is always shown, dp is always honoured).
// ----------------------------------------------------------------------------
module hc595_hex_display
  import spi_pkg::*;
#(
  parameter int CLK_DIV        = 2,
  parameter int N_DIGITS       = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hc595_hex_display_if.slave   bus,
  output logic                 sclk_o,
  output logic                 ser_o,
  output logic                 rclk_o
);

  localparam int NBITS = N_DIGITS * 8;
  localparam int BCW   = $clog2(NBITS) + 1;

  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);
  localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic           ACT_LOW  = (SEG_ACTIVE_LOW != 0);

  disp_state_t           state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  sclk_q, sclk_d;
  logic                  ser_q, ser_d;
  logic                  rclk_q, rclk_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]            div_cnt_q, div_cnt_d;

  logic [4*N_DIGITS-1:0] data_q, data_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic [NBITS-1:0]      shreg_q, shreg_d;

  logic [N_DIGITS-1:0]   blank;
  logic [NBITS-1:0]      enc_bytes;
  logic                  capture;

  assign capture = bus.valid_i && ready_q;

  // --------------------------------------------------------------------------
  // Leading-zero blanking: a digit is blank when it and every digit to its
  // left are zero. Digit 0 (rightmost) is never blanked.
  // --------------------------------------------------------------------------
`ifdef HC595_BLANK_LEADING_ZEROS_EN
  always_comb begin
    logic leading;
    leading = 1'b1;
    blank   = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      leading  = leading && (data_q[4*i +: 4] == 4'h0);
      blank[i] = leading;
    end
  end
`else
  assign blank = '0;
`endif

  // Digit N_DIGITS-1 (leftmost) lands in the top byte so shifting MSB-first
  // sends it first, and it ends up at the far end of the chain.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_enc
    seg7_encoder u_enc (
      .nibble_i     (data_q[4*g +: 4]),
      .dp_i         (dp_q[g]),
      .active_low_i (ACT_LOW),
      .blank_i      (blank[g]),
      .seg_o        (enc_bytes[8*g +: 8])
    );
  end

  // --------------------------------------------------------------------------
  // Next-state / next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    sclk_d    = sclk_q;
    ser_d     = ser_q;
    rclk_d    = rclk_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    data_d    = data_q;
    dp_d      = dp_q;
    shreg_d   = shreg_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (capture) begin
          data_d  = bus.data_i;
          dp_d    = bus.dp_i;
          ready_d = 1'b0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        // First bit is presented together with the first sclk low phase.
        shreg_d   = enc_bytes;
        ser_d     = enc_bytes[NBITS-1];
        sclk_d    = 1'b0;
        bit_cnt_d = '0;
        div_cnt_d = '0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              rclk_d  = 1'b1;
              state_d = LATCH;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shreg_d   = {shreg_q[NBITS-2:0], 1'b0};
              ser_d     = shreg_q[NBITS-2];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      LATCH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          rclk_d    = 1'b0;
          ready_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control state and registered outputs
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      sclk_q    <= 1'b0;
      ser_q     <= 1'b0;
      rclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      sclk_q    <= sclk_d;
      ser_q     <= ser_d;
      rclk_q    <= rclk_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // NOTE: the word and shift registers carry no reset; they are always
  // reloaded before use, and an aborted frame is simply never latched.
  always_ff @(posedge clk_i) begin
    data_q  <= data_d;
    dp_q    <= dp_d;
    shreg_q <= shreg_d;
  end

  assign bus.ready_o = ready_q;
  assign sclk_o      = sclk_q;
  assign ser_o       = ser_q;
  assign rclk_o      = rclk_q;

endmodule

// File: tb/tb_hc595_hex_display.sv
// ----------------------------------------------------------------------------
// tb_hc595_hex_display
//   Three driver instances share clk/rst:
//     dut0 : defaults (CLK_DIV=2, active-low)
//     dut1 : CLK_DIV=2, active-high segments
//     dut2 : CLK_DIV=1, active-low
//   Stimulus pushes expected frames into a scoreboard queue; one monitor per
//   instance reassembles the serial stream on every sclk rise and compares it
//   when rclk drops, along with timing and latency.
// ----------------------------------------------------------------------------
module tb_hc595_hex_display;

  typedef struct {
    logic [63:0] frame;
    int          lat;
  } exp_t;

  localparam logic [7:0] GLYPH [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

`ifdef HC595_BLANK_LEADING_ZEROS_EN
  localparam logic [63:0] EXP_0123 = 64'hFFF9A4B0999282F8;
  localparam logic [63:0] EXP_ZERO = 64'hFFFFFFFFFFFFFFC0;
  localparam logic [63:0] EXP_0A00 = 64'hFFFFFFFFFF88C0C0;
`else
  localparam logic [63:0] EXP_0123 = 64'hC0F9A4B0999282F8;
  localparam logic [63:0] EXP_ZERO = 64'hC0C0C0C0C0C0C0C0;
  localparam logic [63:0] EXP_0A00 = 64'hC0C0C0C0C088C0C0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];

  logic [31:0] data_r [3];
  logic [7:0]  dp_r [3];
  logic [2:0]  valid_r = 3'b000;
  logic [2:0]  ready_w, sclk_w, ser_w, rclk_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hc595_hex_display_if #(.N_DIGITS(8)) bus0 ();
  hc595_hex_display_if #(.N_DIGITS(8)) bus1 ();
  hc595_hex_display_if #(.N_DIGITS(8)) bus2 ();

  assign bus0.data_i = data_r[0];
  assign bus0.dp_i = dp_r[0];
  assign bus0.valid_i = valid_r[0];
  assign ready_w[0] = bus0.ready_o;
  assign bus1.data_i = data_r[1];
  assign bus1.dp_i = dp_r[1];
  assign bus1.valid_i = valid_r[1];
  assign ready_w[1] = bus1.ready_o;
  assign bus2.data_i = data_r[2];
  assign bus2.dp_i = dp_r[2];
  assign bus2.valid_i = valid_r[2];
  assign ready_w[2] = bus2.ready_o;

  hc595_hex_display #(.CLK_DIV(2), .N_DIGITS(8), .SEG_ACTIVE_LOW(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0),
    .sclk_o(sclk_w[0]), .ser_o(ser_w[0]), .rclk_o(rclk_w[0]));
  hc595_hex_display #(.CLK_DIV(2), .N_DIGITS(8), .SEG_ACTIVE_LOW(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1),
    .sclk_o(sclk_w[1]), .ser_o(ser_w[1]), .rclk_o(rclk_w[1]));
  hc595_hex_display #(.CLK_DIV(1), .N_DIGITS(8), .SEG_ACTIVE_LOW(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2),
    .sclk_o(sclk_w[2]), .ser_o(ser_w[2]), .rclk_o(rclk_w[2]));

  function automatic int cd_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction

  // Reference: glyph lookup per digit, leftmost first, dp in bit 7.
  function automatic logic [63:0] model(input logic [31:0] d, input logic [7:0] p,
                                        input bit active_low);
    logic [63:0] f;
    logic [7:0]  b;
    logic [3:0]  nib;
    bit          leading;
    f = '0;
    leading = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nib = d[31 - 4*i -: 4];
      leading = leading && (nib == 4'h0);
      b = GLYPH[nib];
`ifdef HC595_BLANK_LEADING_ZEROS_EN
      if (leading && i != 7) b = 8'h00;
`endif
      b[7] = p[7 - i];
      if (active_low) b = ~b;
      f = {f[55:0], b};
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int g, input logic [63:0] f);
    exp_t e;
    e.frame = f;
    e.lat = 1 + 16 * 8 * cd_of(g) + cd_of(g);
    sb_q.push_back(e);
  endtask

  task automatic wait_ready(input int g);
    int n = 0;
    while (!ready_w[g] && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("dut%0d ready", g), 64'(ready_w[g]), 64'd1);
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    while ((sb_q.size() != 0 || !ready_w[g]) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("dut%0d frames drained", g), 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [31:0] d, input logic [7:0] p,
                      input logic [63:0] f);
    push_exp(g, f);
    wait_ready(g);
    data_r[g] = d;
    dp_r[g] = p;
    valid_r[g] = 1'b1;
    @(posedge clk);
    #1;
    valid_r[g] = 1'b0;
    wait_done(g);
  endtask

  task automatic send_rand(input int g);
    logic [31:0] d;
    logic [7:0]  p;
    d = $urandom >> (4 * $urandom_range(0, 7));
    p = 8'($urandom);
    send(g, d, p, model(d, p, g != 1));
  endtask

  // --------------------------------------------------------------------------
  // Monitors
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int CD = (g == 2) ? 1 : 2;
    logic        sclk_p, rclk_p, ready_p, ser_p;
    int          run_len, nbits, rclk_len, acc_cyc, rclk_rises;
    logic [63:0] frame;
    bit          acc_pend, have_item, stab_err, per_err;
    exp_t        item;

    initial begin
      rclk_rises = 0;
      have_item = 1'b0;
    end

    always @(negedge clk) begin
      if (rst) begin
        sclk_p = 1'b0; rclk_p = 1'b0; ready_p = 1'b0; ser_p = 1'b0;
        run_len = 0; nbits = 0; rclk_len = 0; frame = '0;
        acc_pend = 1'b0; have_item = 1'b0; stab_err = 1'b0; per_err = 1'b0;
      end else begin
        // sclk half-period lengths and ser stability
        if (sclk_w[g] != sclk_p) begin
          if (sclk_p && run_len != CD) per_err = 1'b1;
          if (!sclk_p && nbits > 0 && run_len != CD) per_err = 1'b1;
          run_len = 1;
        end else begin
          run_len++;
        end
        if (sclk_w[g] && !sclk_p) begin
          if (ser_w[g] != ser_p) stab_err = 1'b1;
          frame = {frame[62:0], ser_w[g]};
          nbits++;
        end else if (nbits > 0 && !(sclk_p && !sclk_w[g]) && ser_w[g] != ser_p) begin
          stab_err = 1'b1;
        end

        if (rclk_w[g]) begin
          rclk_len++;
          if (sclk_w[g]) per_err = 1'b1;
          if (!rclk_p) rclk_rises++;
        end
        if (!rclk_w[g] && rclk_p) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d unexpected rclk pulse: got frame %0h expected none", g, frame);
          end else begin
            item = sb_q.pop_front();
            have_item = 1'b1;
            check($sformatf("dut%0d frame", g), frame, item.frame);
            check($sformatf("dut%0d bit count", g), 64'(nbits), 64'd64);
            check($sformatf("dut%0d rclk width", g), 64'(rclk_len), 64'(CD));
            check($sformatf("dut%0d ser stable", g), 64'(stab_err), 64'd0);
            check($sformatf("dut%0d sclk timing", g), 64'(per_err), 64'd0);
          end
          nbits = 0; frame = '0; rclk_len = 0; stab_err = 1'b0; per_err = 1'b0;
        end

        if (ready_w[g] && !ready_p && acc_pend) begin
          if (have_item) begin
            check($sformatf("dut%0d latency", g), 64'(cyc - acc_cyc), 64'(item.lat));
          end else begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d latency: ready returned after %0d cycles with no frame latched",
                     g, cyc - acc_cyc);
          end
          acc_pend = 1'b0;
          have_item = 1'b0;
        end
        if (valid_r[g] && ready_w[g]) begin
          acc_cyc = cyc + 1;
          acc_pend = 1'b1;
        end

        sclk_p = sclk_w[g];
        rclk_p = rclk_w[g];
        ready_p = ready_w[g];
        ser_p = ser_w[g];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] d0, d1;
    logic [7:0]  p0;
    int          rises_before;

    for (int i = 0; i < 3; i++) begin
      data_r[i] = '0;
      dp_r[i] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(ready_w[0]), 64'd0);
    check("reset sclk", 64'(sclk_w[0]), 64'd0);
    check("reset ser", 64'(ser_w[0]), 64'd0);
    check("reset rclk", 64'(rclk_w[0]), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready after reset", 64'(ready_w[0]), 64'd1);

    // Directed words
    send(0, 32'h01234567, 8'h00, EXP_0123);
    send(1, 32'hDEADBEEF, 8'h81, 64'hDE79775E7C7979F1);
    send(0, 32'h00000000, 8'h00, EXP_ZERO);
    send(0, 32'h00000A00, 8'h00, EXP_0A00);
    send(2, 32'h01234567, 8'h00, EXP_0123);

    // Random words on every configuration
    for (int i = 0; i < 5; i++) send_rand(0);
    for (int i = 0; i < 3; i++) send_rand(1);
    for (int i = 0; i < 4; i++) send_rand(2);

    // valid held high with changing data: only the word present on the first
    // ready cycle (259 edges after accept) is taken next.
    wait_ready(0);
    d0 = $urandom;
    p0 = 8'($urandom);
    push_exp(0, model(d0, p0, 1'b1));
    data_r[0] = d0;
    dp_r[0] = p0;
    valid_r[0] = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 260; i++) begin
      #1;
      d1 = $urandom;
      data_r[0] = d1;
      if (i == 260) push_exp(0, model(d1, p0, 1'b1));
      @(posedge clk);
    end
    #1;
    valid_r[0] = 1'b0;
    wait_done(0);

    // Reset at bit 20 of a frame aborts it without a latch pulse
    rises_before = g_mon[0].rclk_rises;
    wait_ready(0);
    data_r[0] = 32'h89ABCDEF;
    dp_r[0] = 8'hFF;
    valid_r[0] = 1'b1;
    @(posedge clk);
    #1;
    valid_r[0] = 1'b0;
    repeat (1 + 20 * 4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort ready", 64'(ready_w[0]), 64'd0);
    check("abort sclk", 64'(sclk_w[0]), 64'd0);
    check("abort ser", 64'(ser_w[0]), 64'd0);
    check("abort rclk", 64'(rclk_w[0]), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready after abort", 64'(ready_w[0]), 64'd1);
    repeat (300) @(posedge clk);
    #1;
    check("no rclk after abort", 64'(g_mon[0].rclk_rises - rises_before), 64'd0);
    send(0, 32'h01234567, 8'h00, EXP_0123);
    send_rand(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hc595_hex_display.md
HC595_HEX_DISPLAY -- requirements
Module: hc595_hex_display

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning clk_i cycles per sclk_o half-period (legal range 1..255).
REQ-002 Parameter N_DIGITS, default 8, meaning number of 74HC595 stages and 7-segment digits in the serial chain.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1, meaning that a shifted 0 lights a segment when set to 1.
REQ-004 clk_i  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 data_i  input  32  eight hex nibbles; data_i[31:28] is the leftmost digit.
REQ-007 dp_i  input  8  decimal-point enables; dp_i[7] belongs to the leftmost digit.
REQ-008 valid_i  input  1  a new display word is offered.
REQ-009 ready_o  output  1  block is idle and accepts a word.
REQ-010 sclk_o  output  1  74HC595 SRCLK (CPOL=0, CPHA=0).
REQ-011 ser_o  output  1  74HC595 SER.
REQ-012 rclk_o  output  1  74HC595 RCLK latch strobe.

Function
REQ-013 A word SHALL be captured only on a cycle with valid_i && ready_o; valid_i while ready_o=0 SHALL be ignored and never queued.
REQ-014 FSM states SHALL be IDLE, LOAD, SHIFT and LATCH: IDLE->LOAD on capture, LOAD->SHIFT after 1 cycle, SHIFT->LATCH after N_DIGITS*8 bits, LATCH->IDLE after CLK_DIV cycles.
REQ-015 ready_o SHALL be 1 only in IDLE.
REQ-016 LOAD SHALL encode each nibble to the byte {dp,g,f,e,d,c,b,a} with active-high values 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71, then invert the byte when SEG_ACTIVE_LOW=1.
REQ-017 The shift order SHALL be the leftmost digit first and MSB (dp) first within each byte, so that the first bit shifted reaches the far end of the chain.
REQ-018 Each bit SHALL occupy 2*CLK_DIV cycles: sclk_o low for CLK_DIV cycles, then high for CLK_DIV cycles; ser_o SHALL change only on the cycle sclk_o goes low and remain stable while sclk_o is high.
REQ-019 In LATCH, sclk_o SHALL be 0, and rclk_o SHALL be 1 for exactly CLK_DIV cycles.
REQ-020 Accept-to-ready latency SHALL be 1 + 16*N_DIGITS*CLK_DIV + CLK_DIV cycles (259 at the defaults).
REQ-021 The bit counter SHALL be $clog2(N_DIGITS*8)+1 bits wide, and the divider counter 8 bits wide; neither SHALL wrap inside a frame.
REQ-022 A back-to-back valid_i on the first IDLE cycle after LATCH SHALL be accepted with no gap.

Reset
REQ-023 While rst_i=1, the state SHALL be IDLE and the outputs SHALL be ready_o=0, sclk_o=0, ser_o=0 and rclk_o=0; ready_o SHALL rise on the first cycle after rst_i falls.
REQ-024 rst_i asserted mid-SHIFT or mid-LATCH SHALL abort the frame on the next edge with no rclk_o pulse, and the partial chain contents SHALL stay unlatched.

Configuration
REQ-025 With HC595_BLANK_LEADING_ZEROS_EN defined, leading zero nibbles SHALL shift as blank bytes (00 active-high, FF active-low), with dp still honoured; the rightmost digit SHALL never be blanked.
REQ-026 Without HC595_BLANK_LEADING_ZEROS_EN, every digit SHALL show its nibble, including leading zeros.

Structure
REQ-027 Package spi_pkg SHALL hold the FSM state enum typedef (disp_state_t), the 16-entry segment table constant and the SEG_* bit-index constants.
REQ-028 Sub-module seg7_encoder (combinational: nibble, dp, active_low, blank -> 8-bit byte) SHALL be instantiated N_DIGITS times.

Verification
REQ-029 Reset, then data_i=32'h01234567, dp_i=0, defaults: the 64-bit stream SHALL be C0 F9 A4 B0 99 92 82 F8, rclk_o high for 2 cycles, and ready_o back 259 cycles after accept.
REQ-030 data_i=32'hDEADBEEF with dp_i=8'h81 and SEG_ACTIVE_LOW=0: the bytes SHALL be DE 79 77 5E 7C 79 79 F1.
REQ-031 valid_i held high through the whole frame with data changing: only the first word is shifted, and the next word is captured on the first ready_o cycle.
REQ-032 rst_i pulsed at bit 20 of a frame: rclk_o never pulses, outputs are 0 on the next edge, and a following frame completes normally.
REQ-033 With HC595_BLANK_LEADING_ZEROS_EN defined, data_i=32'h00000000: the first seven bytes SHALL be FF and the last byte C0; data_i=32'h00000A00: five FF bytes, then 88 C0 C0.
REQ-034 With CLK_DIV=1, the bench SHALL check the sclk_o period is 2 cycles, ser_o is stable across every sclk_o rising edge, and latency is 130 cycles.
